tp_mode_sequencer: RTL and testbench

TP_MODE_SEQUENCER -- requirements
Module: tp_mode_sequencer

---
 rtl/tp_mode_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_tp_mode_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_mode_sequencer.sv
// tp_mode_sequencer: drives the test pattern generator's mode, video timing
// and reset. It watches the generator's VS for frame edges, cycles the
// pattern mode either automatically or on single steps, and reloads timing
// (with a generator reset pulse) when a different resolution is selected.
//
// Ports:
//   I_pxl_clk   pixel clock, sole clock
//   I_rst       asynchronous active-high reset
//   I_vs        vertical sync from the generator
//   I_vs_pol    VS polarity (1 = active-high, 0 = active-low)
//   I_auto      enable automatic mode cycling
//   I_step      single-cycle request to advance the mode once
//   I_res_sel   resolution select (0 = 800x600, 1 = 1024x768, 2 = 1280x720, 3 = as 0)
//   O_mode      pattern mode to the generator
//   O_h_*/O_v_* horizontal / vertical timing for the active resolution
//   O_tp_rst    active-high reset to the generator
//   O_locked    a frame edge has been seen since the last generator reset
//   O_frame_cnt frames counted since the last generator reset
module tp_mode_sequencer #(
  parameter int unsigned FRAMES_PER_MODE = 120,
  parameter int unsigned MODE_MAX        = 3,
  parameter int unsigned RST_CYCLES      = 16
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst,
  input  logic        I_vs,
  input  logic        I_vs_pol,
  input  logic        I_auto,
  input  logic        I_step,
  input  logic [1:0]  I_res_sel,
  output logic [2:0]  O_mode,
  output logic [15:0] O_h_total,
  output logic [15:0] O_h_sync,
  output logic [15:0] O_h_bporch,
  output logic [15:0] O_h_res,
  output logic [15:0] O_v_total,
  output logic [15:0] O_v_sync,
  output logic [15:0] O_v_bporch,
  output logic [15:0] O_v_res,
  output logic        O_tp_rst,
  output logic        O_locked,
  output logic [15:0] O_frame_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned RST_W = 8;
  localparam int unsigned MODE_W = 3;

  localparam logic [CNT_W-1:0]  FPM_LAST  = CNT_W'(FRAMES_PER_MODE - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_MAX);

  typedef enum logic [1:0] {
    ST_RSTP = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] h_total;
    logic [15:0] h_sync;
    logic [15:0] h_bporch;
    logic [15:0] h_res;
    logic [15:0] v_total;
    logic [15:0] v_sync;
    logic [15:0] v_bporch;
    logic [15:0] v_res;
  } timing_t;

  // Resolution timing table; index 3 never reaches here (folded to 0).
  function automatic timing_t lookup(input logic [1:0] entry);
    timing_t t;
    case (entry)
      2'd1:    t = '{16'd1344, 16'd136, 16'd160, 16'd1024, 16'd806, 16'd6, 16'd29, 16'd768};
      2'd2:    t = '{16'd1650, 16'd40,  16'd220, 16'd1280, 16'd750, 16'd5, 16'd20, 16'd720};
      default: t = '{16'd1056, 16'd128, 16'd88,  16'd800,  16'd628, 16'd4, 16'd23, 16'd600};
    endcase
    return t;
  endfunction

  state_t             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic               vs_q, vs_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [CNT_W-1:0]   pm_cnt_q, pm_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               pending_q, pending_d;
  logic               locked_q, locked_d;
  logic               tp_rst_q, tp_rst_d;
  logic [1:0]         res_q, res_d;
  timing_t            timing_q, timing_d;

  logic               vs_act_c;
  logic               frame_tick_c;
  logic [1:0]         res_req_c;
  logic               step_c;
  logic               advance_c;

  // State and output registers.
  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= ST_RSTP;
      rst_cnt_q   <= '0;
      vs_q        <= 1'b0;
      mode_q      <= '0;
      pm_cnt_q    <= '0;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      locked_q    <= 1'b0;
      tp_rst_q    <= 1'b1;
      res_q       <= 2'd0;
      timing_q    <= lookup(2'd0);
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      vs_q        <= vs_d;
      mode_q      <= mode_d;
      pm_cnt_q    <= pm_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pending_q   <= pending_d;
      locked_q    <= locked_d;
      tp_rst_q    <= tp_rst_d;
      res_q       <= res_d;
      timing_q    <= timing_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    vs_act_c     = ~(I_vs ^ I_vs_pol);
    frame_tick_c = vs_act_c & ~vs_q;
    res_req_c    = (I_res_sel == 2'd3) ? 2'd0 : I_res_sel;
    // A step arriving in the same cycle as a consuming tick still counts.
    step_c       = pending_q | I_step;
    advance_c    = 1'b0;

    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    vs_d        = vs_act_c;
    mode_d      = mode_q;
    pm_cnt_d    = pm_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pending_d   = step_c;
    locked_d    = locked_q;
    tp_rst_d    = tp_rst_q;
    res_d       = res_q;
    timing_d    = timing_q;

    case (state_q)
      ST_RSTP: begin
        tp_rst_d    = 1'b1;
        locked_d    = 1'b0;
        frame_cnt_d = '0;
        pm_cnt_d    = '0;
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_SYNC;
          rst_cnt_d = '0;
          tp_rst_d  = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      ST_SYNC: begin
        if (frame_tick_c) begin
          state_d  = ST_RUN;
          locked_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (frame_tick_c) begin
          if (res_req_c != res_q) begin
            // New resolution: load timing now and restart the generator.
            res_d       = res_req_c;
            timing_d    = lookup(res_req_c);
            state_d     = ST_RSTP;
            rst_cnt_d   = '0;
            tp_rst_d    = 1'b1;
            locked_d    = 1'b0;
            frame_cnt_d = '0;
            pm_cnt_d    = '0;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            advance_c   = step_c | (I_auto & (pm_cnt_q == FPM_LAST));
            if (advance_c) begin
              mode_d    = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
              pm_cnt_d  = '0;
              pending_d = 1'b0;
            end else begin
              // Wrap so the auto compare is reachable after manual dwell.
              pm_cnt_d = (pm_cnt_q == FPM_LAST) ? '0 : pm_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = ST_RSTP;
      end
    endcase
  end

  assign O_mode      = mode_q;
  assign O_h_total   = timing_q.h_total;
  assign O_h_sync    = timing_q.h_sync;
  assign O_h_bporch  = timing_q.h_bporch;
  assign O_h_res     = timing_q.h_res;
  assign O_v_total   = timing_q.v_total;
  assign O_v_sync    = timing_q.v_sync;
  assign O_v_bporch  = timing_q.v_bporch;
  assign O_v_res     = timing_q.v_res;
  assign O_tp_rst    = tp_rst_q;
  assign O_locked    = locked_q;
  assign O_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tp_mode_sequencer.sv
// Self-checking bench for tp_mode_sequencer: randomized VS/step/resolution
// stimulus against a frame-level behavioural model, plus literal checks.
module tb_tp_mode_sequencer;

  localparam int FPM  = 2;
  localparam int MMAX = 3;
  localparam int RSTC = 16;

  localparam int T_HTOT[3] = '{1056, 1344, 1650};
  localparam int T_HSYN[3] = '{128, 136, 40};
  localparam int T_HBP[3]  = '{88, 160, 220};
  localparam int T_HRES[3] = '{800, 1024, 1280};
  localparam int T_VTOT[3] = '{628, 806, 750};
  localparam int T_VSYN[3] = '{4, 6, 5};
  localparam int T_VBP[3]  = '{23, 29, 20};
  localparam int T_VRES[3] = '{600, 768, 720};

  logic        clk = 1'b0;
  logic        rst;
  logic        vs, vs_pol, auto_en, step;
  logic [1:0]  res_sel;
  logic [2:0]  o_mode;
  logic [15:0] o_h_total, o_h_sync, o_h_bporch, o_h_res;
  logic [15:0] o_v_total, o_v_sync, o_v_bporch, o_v_res;
  logic        o_tp_rst, o_locked;
  logic [15:0] o_frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tp_mode_sequencer #(
    .FRAMES_PER_MODE(FPM),
    .MODE_MAX(MMAX),
    .RST_CYCLES(RSTC)
  ) dut (
    .I_pxl_clk(clk),
    .I_rst(rst),
    .I_vs(vs),
    .I_vs_pol(vs_pol),
    .I_auto(auto_en),
    .I_step(step),
    .I_res_sel(res_sel),
    .O_mode(o_mode),
    .O_h_total(o_h_total),
    .O_h_sync(o_h_sync),
    .O_h_bporch(o_h_bporch),
    .O_h_res(o_h_res),
    .O_v_total(o_v_total),
    .O_v_sync(o_v_sync),
    .O_v_bporch(o_v_bporch),
    .O_v_res(o_v_res),
    .O_tp_rst(o_tp_rst),
    .O_locked(o_locked),
    .O_frame_cnt(o_frame_cnt)
  );

  // Behavioural model: generator-reset clocks left, lock flag, counters.
  typedef struct {
    int rst_left;
    bit locked;
    int frames;
    int mode;
    int fim;
    bit pend;
    int entry;
    bit vs_prev;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t s;
    s.rst_left = RSTC;
    s.locked   = 1'b0;
    s.frames   = 0;
    s.mode     = 0;
    s.fim      = 0;
    s.pend     = 1'b0;
    s.entry    = 0;
    s.vs_prev  = 1'b0;
    return s;
  endfunction

  function automatic model_t model_step(model_t s, bit vs_i, bit pol_i,
                                        bit step_i, bit auto_i, int sel_i);
    model_t n;
    bit act;
    bit tick;
    int want;
    n = s;
    act = pol_i ? vs_i : !vs_i;
    tick = act && !s.vs_prev;
    n.vs_prev = act;
    if (step_i) n.pend = 1'b1;
    if (s.rst_left > 0) begin
      n.rst_left = s.rst_left - 1;
      n.locked = 1'b0;
      n.frames = 0;
      n.fim = 0;
    end else if (!s.locked) begin
      if (tick) n.locked = 1'b1;
    end else if (tick) begin
      want = (sel_i == 3) ? 0 : sel_i;
      if (want != s.entry) begin
        n.entry = want;
        n.rst_left = RSTC;
        n.locked = 1'b0;
        n.frames = 0;
        n.fim = 0;
      end else begin
        n.frames = (s.frames + 1) % 65536;
        if (n.pend || (auto_i && s.fim == FPM - 1)) begin
          n.mode = (s.mode + 1) % (MMAX + 1);
          n.fim = 0;
          n.pend = 1'b0;
        end else begin
          n.fim = (s.fim + 1) % FPM;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, vs, vs_pol, step, auto_en, int'(res_sel));
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit exp_rst;
    exp_rst = (m.rst_left > 0);
    n_tests++;
    if (int'(o_mode) != m.mode || o_tp_rst != exp_rst || o_locked != m.locked ||
        int'(o_frame_cnt) != m.frames ||
        int'(o_h_total) != T_HTOT[m.entry] || int'(o_h_sync) != T_HSYN[m.entry] ||
        int'(o_h_bporch) != T_HBP[m.entry] || int'(o_h_res) != T_HRES[m.entry] ||
        int'(o_v_total) != T_VTOT[m.entry] || int'(o_v_sync) != T_VSYN[m.entry] ||
        int'(o_v_bporch) != T_VBP[m.entry] || int'(o_v_res) != T_VRES[m.entry]) begin
      n_fail++;
      $display("FAIL cycle_compare t=%0t got mode=%0d rst=%0d lock=%0d fc=%0d htot=%0d vres=%0d hsync=%0d vtot=%0d expected mode=%0d rst=%0d lock=%0d fc=%0d htot=%0d vres=%0d hsync=%0d vtot=%0d",
               $time, o_mode, o_tp_rst, o_locked, o_frame_cnt, o_h_total, o_v_res,
               o_h_sync, o_v_total, m.mode, exp_rst, m.locked, m.frames,
               T_HTOT[m.entry], T_VRES[m.entry], T_HSYN[m.entry], T_VTOT[m.entry]);
    end
  end

  // Mode-change log used by the auto-sequence check.
  bit   log_en = 1'b0;
  int   mode_log[$];
  logic [2:0] last_mode = 3'd0;
  always @(negedge clk) begin
    if (log_en && o_mode != last_mode) mode_log.push_back(int'(o_mode));
    last_mode <= o_mode;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // VS frame generator: active for 3 clocks, frame length 8..14 clocks.
  int vs_pos = 0;
  int vs_len = 10;

  task automatic tick1(input bit stp);
    @(posedge clk);
    #1;
    vs_pos++;
    if (vs_pos >= vs_len) begin
      vs_pos = 0;
      vs_len = $urandom_range(8, 14);
    end
    vs = vs_pol ? (vs_pos < 3) : !(vs_pos < 3);
    step = stp;
  endtask

  task automatic set_pol(input bit p);
    vs_pol = p;
    vs = vs_pol ? (vs_pos < 3) : !(vs_pos < 3);
  endtask

  task automatic wait_tp_rst(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick1(1'b0);
      @(negedge clk);
      if (o_tp_rst) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic count_pulse(input string name, input int already);
    int cnt;
    bit done;
    cnt = already;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick1(1'b0);
      @(negedge clk);
      if (o_tp_rst) cnt++;
      else done = 1'b1;
    end
    chk(name, cnt, RSTC);
  endtask

  task automatic wait_lock(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick1(1'b0);
      @(negedge clk);
      if (o_locked) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, m0, seen, budget;
    bit done;
    rst = 1'b1; vs = 1'b0; vs_pol = 1'b1; auto_en = 1'b0; step = 1'b0; res_sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tp_rst", int'(o_tp_rst), 1);
    chk("rst_mode", int'(o_mode), 0);
    chk("rst_h_total", int'(o_h_total), 1056);
    chk("rst_locked", int'(o_locked), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Pulse length after reset release, then lock and count frames.
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (o_tp_rst) cnt++;
      else done = 1'b1;
      if (!done) tick1(1'b0);
    end
    chk("rst_pulse_len", cnt, 16);
    wait_lock("lock_after_reset");
    repeat (60) tick1(1'b0);

    // Auto cycling from mode 0.
    chk("auto_start_mode0", int'(o_mode), 0);
    mode_log.delete();
    log_en = 1'b1;
    auto_en = 1'b1;
    for (int i = 0; i < 400 && mode_log.size() < 4; i++) tick1(1'b0);
    log_en = 1'b0;
    chk("auto_seq_len", int'(mode_log.size() >= 4), 1);
    if (mode_log.size() >= 4) begin
      chk("auto_seq_0", mode_log[0], 1);
      chk("auto_seq_1", mode_log[1], 2);
      chk("auto_seq_2", mode_log[2], 3);
      chk("auto_seq_3", mode_log[3], 0);
    end

    // Three steps inside one frame: exactly one advance.
    auto_en = 1'b0;
    for (int i = 0; i < 40 && vs_pos != 3; i++) tick1(1'b0);
    m0 = m.mode;
    tick1(1'b1); tick1(1'b1); tick1(1'b1); tick1(1'b0);
    for (int i = 0; i < 40 && vs_pos != 0; i++) tick1(1'b0);
    tick1(1'b0);
    @(negedge clk);
    chk("step_once", int'(o_mode), (m0 + 1) % (MMAX + 1));

    // Step on the same tick as auto candidates.
    auto_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 20 && (vs_pos + 1 < vs_len); i++) tick1(1'b0);
      tick1(1'b1);
    end
    tick1(1'b0);

    // Resolution 0 -> 2 in RUN.
    auto_en = 1'b0;
    repeat (20) tick1(1'b0);
    m0 = m.mode;
    res_sel = 2'd2;
    wait_tp_rst("res2_tp_rst_rise");
    chk("res2_h_total", int'(o_h_total), 1650);
    chk("res2_v_res", int'(o_v_res), 720);
    chk("res2_locked_low", int'(o_locked), 0);
    chk("res2_frame_cnt", int'(o_frame_cnt), 0);
    chk("res2_mode_kept", int'(o_mode), m0);
    count_pulse("res2_pulse_len", 1);
    wait_lock("res2_relock");

    // Active-low VS, back to entry 0, then select 3 must not reconfigure.
    set_pol(1'b0);
    repeat (30) tick1(1'b0);
    res_sel = 2'd0;
    wait_tp_rst("res0_tp_rst_rise");
    chk("res0_h_total", int'(o_h_total), 1056);
    count_pulse("res0_pulse_len", 1);
    wait_lock("res0_relock");
    res_sel = 2'd3;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick1(1'b0);
      @(negedge clk);
      if (o_tp_rst) seen++;
    end
    chk("sel3_no_reconfig", seen, 0);
    chk("sel3_h_total", int'(o_h_total), 1056);

    // Randomized operation.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) res_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 299) == 0) set_pol(~vs_pol);
      tick1($urandom_range(0, 15) == 0);
    end

    // Asynchronous reset in RUN with mode 2.
    auto_en = 1'b1;
    step = 1'b0;
    done = 1'b0;
    budget = 0;
    while (!done && budget < 1500) begin
      tick1(1'b0);
      budget++;
      if (m.mode == 2 && m.locked && m.rst_left == 0) done = 1'b1;
    end
    chk("reach_mode2", int'(done), 1);
    chk("mid_run_mode2", int'(o_mode), 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mode", int'(o_mode), 0);
    chk("async_rst_h_total", int'(o_h_total), 1056);
    chk("async_rst_v_res", int'(o_v_res), 600);
    chk("async_rst_tp_rst", int'(o_tp_rst), 1);
    chk("async_rst_locked", int'(o_locked), 0);
    chk("async_rst_frame_cnt", int'(o_frame_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (150) tick1(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
